// File: rtl/bus_package.sv
// Shared definitions for the split request/response system bus.
// Provides the tag and command field widths, the bus_read command encoding
// and the width of one fetched line.
package bus_package;

    localparam int unsigned TAG_WIDTH       = 4;
    localparam int unsigned CMD_WIDTH       = 3;
    localparam int unsigned READ_LINE_WIDTH = 128;

    localparam logic [CMD_WIDTH-1:0] bus_read = 3'd1;

endpackage : bus_package

// File: rtl/line_fetch_master.sv
// Bus master that fetches one 128-bit line per consumer request from a
// read-only slave over the split request/response bus.
//
// Ports
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   fetch_valid/fetch_ready      consumer request handshake (ready only when idle)
//   fetch_address                byte address, low 4 bits dropped to align to a line
//   line_valid/line_error        one-cycle completion pulse, error qualifies it
//   line_data                    fetched line, held until the next completion
//   request_breq/request_bgnt    request-bus arbitration
//   request_oe/address/command/tag  request bus drive, zero when not driving
//   nack                         slave refusal, sampled in the request_oe cycle
//   response_oe/tag/data         response bus, matched on MASTER_TAG while waiting
module line_fetch_master
    import bus_package::*;
#(
    parameter logic [TAG_WIDTH-1:0] MASTER_TAG     = '0,
    parameter int unsigned          MAX_RETRY      = 15,
    parameter int unsigned          BACKOFF_CYCLES = 4,
    parameter int unsigned          TIMEOUT_CYCLES = 1023
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_address,
    output logic                       fetch_ready,

    output logic                       line_valid,
    output logic                       line_error,
    output logic [READ_LINE_WIDTH-1:0] line_data,

    output logic                       request_breq,
    input  logic                       request_bgnt,
    output logic                       request_oe,
    output logic [31:0]                request_address,
    output logic [CMD_WIDTH-1:0]       request_command,
    output logic [TAG_WIDTH-1:0]       request_tag,
    input  logic                       nack,

    input  logic [READ_LINE_WIDTH-1:0] response_data,
    input  logic [TAG_WIDTH-1:0]       response_tag,
    input  logic                       response_oe
);

    localparam int unsigned RETRY_W   = (MAX_RETRY > 0)      ? $clog2(MAX_RETRY + 1)      : 1;
    localparam int unsigned TIMEOUT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned BACKOFF_W = (BACKOFF_CYCLES > 0) ? $clog2(BACKOFF_CYCLES + 1) : 1;

    localparam logic [RETRY_W-1:0]   RETRY_LIMIT   = RETRY_W'(MAX_RETRY);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [BACKOFF_W-1:0] BACKOFF_LAST  =
        BACKOFF_W'((BACKOFF_CYCLES > 0) ? BACKOFF_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        BACKOFF,
        WAIT,
        DONE
    } state_t;

    state_t                     state_q,      state_d;
    logic [31:0]                address_q,    address_d;
    logic [RETRY_W-1:0]         retry_q,      retry_d;
    logic [BACKOFF_W-1:0]       backoff_q,    backoff_d;
    logic [TIMEOUT_W-1:0]       timeout_q,    timeout_d;
    logic                       line_valid_q, line_valid_d;
    logic                       line_error_q, line_error_d;
    logic [READ_LINE_WIDTH-1:0] line_data_q,  line_data_d;

    logic response_match;
    logic unused_address_bits;

    // Line alignment discards the byte offset within the line.
    assign unused_address_bits = ^fetch_address[3:0];

    assign response_match = response_oe && (response_tag == MASTER_TAG);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            retry_q      <= '0;
            backoff_q    <= '0;
            timeout_q    <= '0;
            line_valid_q <= 1'b0;
            line_error_q <= 1'b0;
            line_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            retry_q      <= retry_d;
            backoff_q    <= backoff_d;
            timeout_q    <= timeout_d;
            line_valid_q <= line_valid_d;
            line_error_q <= line_error_d;
            line_data_q  <= line_data_d;
        end
    end

    // The completion flops are loaded on the transition into DONE, so the
    // registered line_valid pulse lines up with the single DONE cycle.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        retry_d      = retry_q;
        backoff_d    = backoff_q;
        timeout_d    = timeout_q;
        line_valid_d = 1'b0;
        line_error_d = 1'b0;
        line_data_d  = line_data_q;

        case (state_q)
            IDLE: begin
                if (fetch_valid) begin
                    address_d = {fetch_address[31:4], 4'b0000};
                    retry_d   = '0;
                    state_d   = ARB;
                end
            end

            ARB: begin
                if (request_bgnt) begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (!nack) begin
                    timeout_d = '0;
                    state_d   = WAIT;
                end else if (retry_q == RETRY_LIMIT) begin
                    line_valid_d = 1'b1;
                    line_error_d = 1'b1;
                    line_data_d  = '0;
                    state_d      = DONE;
                end else begin
                    retry_d   = retry_q + 1'b1;
                    backoff_d = '0;
                    state_d   = (BACKOFF_CYCLES == 0) ? ARB : BACKOFF;
                end
            end

            BACKOFF: begin
                if (backoff_q == BACKOFF_LAST) begin
                    state_d = ARB;
                end else begin
                    backoff_d = backoff_q + 1'b1;
                end
            end

            WAIT: begin
                // A matching beat takes priority over an expiring timeout.
                if (response_match) begin
                    line_valid_d = 1'b1;
                    line_data_d  = response_data;
                    state_d      = DONE;
                end else if (timeout_q == TIMEOUT_LIMIT) begin
                    line_valid_d = 1'b1;
                    line_error_d = 1'b1;
                    line_data_d  = '0;
                    state_d      = DONE;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetch_ready     = (state_q == IDLE);
    assign request_breq    = (state_q == ARB);
    assign request_oe      = (state_q == ISSUE);
    assign request_address = request_oe ? address_q  : '0;
    assign request_command = request_oe ? bus_read   : '0;
    assign request_tag     = request_oe ? MASTER_TAG : '0;

    assign line_valid = line_valid_q;
    assign line_error = line_error_q;
    assign line_data  = line_data_q;

endmodule : line_fetch_master
